// File: rtl/count_sched.sv
// count_sched: two-client scheduler that hands one WIDTH-bit counter to one client at a time for a run of len ticks.
// Define COUNT_SCHED_FIXED_PRIO_EN for fixed priority (client0 wins contention); default build is round-robin.
module count_sched #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [2*WIDTH-1:0] req_len,
  output logic [1:0]         req_ready,
  input  logic               pause,
  output logic [WIDTH-1:0]   val,
  output logic               busy,
  output logic               owner,
  output logic [1:0]         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] len;
  logic [WIDTH-1:0] win_len;
  logic [WIDTH-1:0] val_inc;
  logic             win;

`ifndef COUNT_SCHED_FIXED_PRIO_EN
  logic last;
`endif

  // Arbitration winner; only meaningful when at least one request is asserted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    win = 1'b0;
    if (req_valid == 2'b10) begin
      win = 1'b1;
    end else if (req_valid == 2'b11) begin
`ifdef COUNT_SCHED_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~last;
`endif
    end
  end

  assign win_len   = win ? req_len[2*WIDTH-1:WIDTH] : req_len[WIDTH-1:0];
  assign req_ready = (state == IDLE && req_valid[win]) ? (2'b01 << win) : 2'b00;
  assign val_inc   = val + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      val   <= '0;
      len   <= '0;
      owner <= 1'b0;
`ifndef COUNT_SCHED_FIXED_PRIO_EN
      last  <= 1'b1;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (|req_ready) begin
            len   <= win_len;
            owner <= win;
            val   <= '0;
            state <= (win_len == '0) ? DONE : RUN;
`ifndef COUNT_SCHED_FIXED_PRIO_EN
            last  <= win;
`endif
          end
        end
        RUN: begin
          if (!pause) begin
            val <= val_inc;
            if (val_inc == len) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs decode straight from registered state and owner.
  assign busy = (state != IDLE);
  assign done = (state == DONE) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule
